// File: rtl/zero_run_controller.sv
// Run sequencer for the Zero instruction executor core: init pulse, stepping,
// step limit, and out-channel checking against a loaded expected table.
module zero_run_controller #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut               = 100,
    parameter int MaxSteps           = 1000,
    parameter int AW                 = $clog2(NOut + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          exp_we,
    input  logic [AW-1:0]                 exp_addr,
    input  logic [MemoryElementWidth-1:0] exp_data,
    input  logic [AW-1:0]                 exp_count,
    output logic                          core_init,
    output logic                          step,
    input  logic                          core_done,
    input  logic                          out_valid,
    input  logic [MemoryElementWidth-1:0] out_data,
    output logic                          finished,
    output logic                          success,
    output logic                          timeout,
    output logic [31:0]                   steps,
    output logic [AW-1:0]                 out_count,
    output logic [AW-1:0]                 first_bad
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [AW-1:0]                 exp_count_q, exp_count_d;
    logic [31:0]                   steps_q, steps_d;
    logic [AW-1:0]                 out_count_q, out_count_d;
    logic [AW-1:0]                 first_bad_q, first_bad_d;
    logic                          mismatch_q, mismatch_d;
    logic                          success_q, success_d;
    logic                          timeout_q, timeout_d;

    logic [MemoryElementWidth-1:0] exp_mem [NOut];
    logic [MemoryElementWidth-1:0] exp_rd;
    logic                          out_bad;

    // Expected table has no reset so a loaded program survives a reset.
    always_ff @(posedge clock) begin
        if (!reset && state_q == S_IDLE && exp_we && exp_addr < AW'(NOut)) begin
            exp_mem[exp_addr] <= exp_data;
        end
    end

    always_comb begin
        exp_rd = '0;
        if (out_count_q < AW'(NOut)) begin
            exp_rd = exp_mem[out_count_q];
        end
    end

    assign out_bad = (out_count_q >= exp_count_q) || (out_data != exp_rd);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            exp_count_q <= '0;
            steps_q     <= '0;
            out_count_q <= '0;
            first_bad_q <= '0;
            mismatch_q  <= 1'b0;
            success_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_count_q <= exp_count_d;
            steps_q     <= steps_d;
            out_count_q <= out_count_d;
            first_bad_q <= first_bad_d;
            mismatch_q  <= mismatch_d;
            success_q   <= success_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        exp_count_d = exp_count_q;
        steps_d     = steps_q;
        out_count_d = out_count_q;
        first_bad_d = first_bad_q;
        mismatch_d  = mismatch_q;
        success_d   = success_q;
        timeout_d   = timeout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    exp_count_d = exp_count;
                    state_d     = S_INIT;
                end
            end
            S_INIT: begin
                steps_d     = '0;
                out_count_d = '0;
                first_bad_d = '0;
                mismatch_d  = 1'b0;
                success_d   = 1'b0;
                timeout_d   = 1'b0;
                state_d     = S_RUN;
            end
            S_RUN: begin
                steps_d = steps_q + 32'd1;
                if (out_valid) begin
                    if (out_bad && !mismatch_q) begin
                        mismatch_d  = 1'b1;
                        first_bad_d = out_count_q;
                    end
                    if (out_count_q != AW'(NOut)) begin
                        out_count_d = out_count_q + AW'(1);
                    end
                end
                // core_done takes priority over the step limit in the same cycle
                if (core_done) begin
                    state_d = S_CHECK;
                end else if (steps_q + 32'd1 == 32'(MaxSteps)) begin
                    timeout_d = 1'b1;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!mismatch_q && out_count_q < exp_count_q) begin
                    first_bad_d = out_count_q;
                end
                success_d = !mismatch_q && !timeout_q && (out_count_q == exp_count_q);
                state_d   = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign core_init = (state_q == S_INIT);
    assign step      = (state_q == S_RUN);
    assign finished  = (state_q == S_DONE);
    assign success   = success_q;
    assign timeout   = timeout_q;
    assign steps     = steps_q;
    assign out_count = out_count_q;
    assign first_bad = first_bad_q;

endmodule

// File: tb/tb_zero_run_controller.sv
// Directed bench for zero_run_controller: a tiny core model driven from the
// step output, with hand-computed results per run.
module tb_zero_run_controller;
    localparam int MW  = 12;
    localparam int NO  = 100;
    localparam int MS  = 7;
    localparam int AW  = $clog2(NO + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [MW-1:0] exp_data;
    logic [AW-1:0] exp_count;
    logic          core_init;
    logic          step;
    logic          core_done;
    logic          out_valid;
    logic [MW-1:0] out_data;
    logic          finished;
    logic          success;
    logic          timeout;
    logic [31:0]   steps;
    logic [AW-1:0] out_count;
    logic [AW-1:0] first_bad;

    int n_tests = 0;
    int n_fail  = 0;
    int emit [8];
    int done_cyc;
    int fin_cyc;

    zero_run_controller #(
        .MemoryElementWidth(MW),
        .NOut(NO),
        .MaxSteps(MS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .exp_we(exp_we),
        .exp_addr(exp_addr),
        .exp_data(exp_data),
        .exp_count(exp_count),
        .core_init(core_init),
        .step(step),
        .core_done(core_done),
        .out_valid(out_valid),
        .out_data(out_data),
        .finished(finished),
        .success(success),
        .timeout(timeout),
        .steps(steps),
        .out_count(out_count),
        .first_bad(first_bad)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int a, input int d);
        @(negedge clock);
        exp_we   = 1'b1;
        exp_addr = AW'(a);
        exp_data = MW'(d);
        @(negedge clock);
        exp_we   = 1'b0;
    endtask

    // Core model: output i on step i+2, core_done on step done_at (0 = never).
    task automatic run(input int n_emit, input int done_at, input int reset_at, input int we_at);
        int k = 0;
        done_cyc = -1;
        fin_cyc  = -1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("core_init_pulse", 32'(core_init), 1);
        check("no_step_in_init", 32'(step), 0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            out_valid = 1'b0;
            core_done = 1'b0;
            exp_we    = 1'b0;
            if (finished) begin
                fin_cyc = c;
                break;
            end
            if (step) begin
                k++;
                if (k >= 2 && k - 2 < n_emit) begin
                    out_valid = 1'b1;
                    out_data  = MW'(emit[k-2]);
                end
                if (k == done_at) begin
                    core_done = 1'b1;
                    done_cyc  = c;
                end
                if (k == we_at) begin
                    exp_we   = 1'b1;
                    exp_addr = '0;
                    exp_data = MW'(9);
                end
                if (k == reset_at) begin
                    reset = 1'b1;
                    @(negedge clock);
                    reset     = 1'b0;
                    out_valid = 1'b0;
                    core_done = 1'b0;
                    check("reset_step_low", 32'(step), 0);
                    check("reset_finished", 32'(finished), 0);
                    check("reset_steps", steps, 0);
                    return;
                end
            end
        end
        if (fin_cyc < 0) check("finish_within_budget", 0, 1);
        check("step_low_when_done", 32'(step), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
        exp_count = AW'(3); core_done = 1'b0; out_valid = 1'b0; out_data = '0;
        @(negedge clock);
        @(negedge clock);
        check("rst_finished", 32'(finished), 0);
        check("rst_step", 32'(step), 0);
        check("rst_core_init", 32'(core_init), 0);
        check("rst_success", 32'(success), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_steps", steps, 0);
        reset = 1'b0;

        load(0, 3); load(1, 0); load(2, 1);

        // 1: matching stream, done at step 6
        emit[0] = 3; emit[1] = 0; emit[2] = 1;
        run(3, 6, 0, 0);
        check("t1_finished", 32'(finished), 1);
        check("t1_success", 32'(success), 1);
        check("t1_steps", steps, 6);
        check("t1_out_count", 32'(out_count), 3);
        check("t1_timeout", 32'(timeout), 0);
        check("t1_done_to_finished", 32'(fin_cyc - done_cyc), 2);

        // 2: second element wrong
        emit[1] = 1;
        run(3, 6, 0, 0);
        check("t2_success", 32'(success), 0);
        check("t2_first_bad", 32'(first_bad), 1);
        check("t2_finished", 32'(finished), 1);

        // 3: never done, step limit reached
        emit[1] = 0;
        run(3, 0, 0, 0);
        check("t3_timeout", 32'(timeout), 1);
        check("t3_steps", steps, 7);
        check("t3_success", 32'(success), 0);

        // 4a: one output missing
        run(2, 6, 0, 0);
        check("t4a_first_bad", 32'(first_bad), 2);
        check("t4a_success", 32'(success), 0);

        // 4b: extra output, last one written together with core_done
        emit[3] = 5;
        run(4, 5, 0, 0);
        check("t4b_first_bad", 32'(first_bad), 3);
        check("t4b_out_count", 32'(out_count), 4);
        check("t4b_success", 32'(success), 0);

        // 5: core_done on the limit step wins over timeout
        run(3, 7, 0, 0);
        check("t5_timeout", 32'(timeout), 0);
        check("t5_success", 32'(success), 1);
        check("t5_steps", steps, 7);

        // 5b: table write attempted during RUN is ignored
        run(3, 6, 0, 2);
        check("t5b_we_run_success", 32'(success), 1);
        run(3, 6, 0, 0);
        check("t5b_rerun_success", 32'(success), 1);
        check("t5b_rerun_first_bad", 32'(first_bad), 0);

        // 6: reset at step 3, then clean rerun
        run(3, 6, 3, 0);
        run(3, 6, 0, 0);
        check("t6_rerun_success", 32'(success), 1);
        check("t6_rerun_steps", steps, 6);
        check("t6_rerun_out_count", 32'(out_count), 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
